// File: rtl/alu_operand_arbiter.sv
// alu_operand_arbiter: round-robin capture of one of four operands into a valid/ready output register
module alu_operand_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic             sel_s0,
  output logic             sel_s1,
  output logic             busy
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [1:0] last_grant;
  logic [1:0] win;
  logic [1:0] idx;
  logic found;
  logic open;
  logic [WIDTH-1:0] mux_lo, mux_hi, mux_out;
  // scan requesters starting just after the last grant; first active one wins
  always_comb begin
    found = 1'b0;
    win = 2'd0;
    idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign open = (state == EMPTY) || (out_ready && state == FULL);
  assign req_ready = (rst_n && open && found) ? (4'b0001 << win) : 4'b0000;
  assign mux_lo = win[0] ? req_data1 : req_data0;
  assign mux_hi = win[0] ? req_data3 : req_data2;
  assign mux_out = win[1] ? mux_hi : mux_lo;
  // capture winner when the window is open, drain to EMPTY on a handshake with no winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_data <= '0;
      out_src <= 2'd0;
      last_grant <= 2'd3;
    end else if (open && found) begin
      state <= FULL;
      out_data <= mux_out;
      out_src <= win;
      last_grant <= win;
    end else if (open) begin
      state <= EMPTY;
    end
  end
  assign out_valid = (state == FULL);
  assign busy = out_valid;
  assign sel_s0 = out_src[0];
  assign sel_s1 = out_src[1];
endmodule

// File: tb/tb_alu_operand_arbiter.sv
// tb_alu_operand_arbiter: directed scenario tests for the round-robin operand arbiter
module tb_alu_operand_arbiter;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        sel_s0, sel_s1, busy;
  int pass_cnt = 0;
  int total = 0;

  alu_operand_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .sel_s0(sel_s0), .sel_s1(sel_s1), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    total++;
    if ({out_valid, busy, out_src, sel_s1, sel_s0, out_data} !== {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0})
      $display("FAIL reset_outputs: got v=%b b=%b src=%0d s=%b%b d=%h want all zero", out_valid, busy, out_src, sel_s1, sel_s0, out_data);
    else pass_cnt++;
    total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 4'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_data2 = 32'hDEADBEEF;
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({out_valid, out_data, out_src, sel_s1, sel_s0} !== {1'b1, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0})
      $display("FAIL single_capture: got v=%b d=%h src=%0d s=%b%b want v=1 d=deadbeef src=2 s=10", out_valid, out_data, out_src, sel_s1, sel_s0);
    else pass_cnt++;
    req_valid = 4'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_drain: got out_valid=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    do_reset();
    req_data0 = 32'h10000000;
    req_data1 = 32'h10000001;
    req_data2 = 32'h10000002;
    req_data3 = 32'h10000003;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL rr_first_ready: got %b want 0001", req_ready);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g = 2'(k);
      total++;
      if ({out_valid, out_src, out_data} !== {1'b1, g, 30'h04000000, g})
        $display("FAIL rr_grant_%0d: got v=%b src=%0d d=%h want v=1 src=%0d", k, out_valid, out_src, out_data, g);
      else pass_cnt++;
      total++;
      if (req_ready !== (4'b0001 << (g + 2'd1)))
        $display("FAIL rr_ready_%0d: got %b want grant to %0d", k, req_ready, g + 2'd1);
      else pass_cnt++;
    end
    req_valid = 4'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL rr_drain: got out_valid=%b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_data1 = 32'hA1A1A1A1;
    req_data2 = 32'hB2B2B2B2;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ({out_valid, out_data, out_src, sel_s1, sel_s0, req_ready} !== {1'b1, 32'hA1A1A1A1, 2'd1, 1'b0, 1'b1, 4'b0000})
        $display("FAIL bp_hold_%0d: got v=%b d=%h src=%0d s=%b%b rdy=%b want v=1 d=a1a1a1a1 src=1 s=01 rdy=0000", k, out_valid, out_data, out_src, sel_s1, sel_s0, req_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) $display("FAIL bp_release_ready: got %b want 0100", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd2, 32'hB2B2B2B2})
      $display("FAIL bp_next: got v=%b src=%0d d=%h want v=1 src=2 d=b2b2b2b2", out_valid, out_src, out_data);
    else pass_cnt++;
    req_valid = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b1000;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_src !== 2'd3) $display("FAIL wrap_first: got src=%0d want 3", out_src);
    else pass_cnt++;
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL wrap_ready0: got %b want 0001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({out_src, req_ready} !== {2'd0, 4'b1000}) $display("FAIL wrap_grant0: got src=%0d rdy=%b want src=0 rdy=1000", out_src, req_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({out_valid, out_src} !== {1'b1, 2'd3}) $display("FAIL wrap_grant3: got v=%b src=%0d want v=1 src=3", out_valid, out_src);
    else pass_cnt++;
    req_valid = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data0 = 32'hCAFEF00D;
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_data} !== {1'b1, 32'hCAFEF00D}) $display("FAIL mid_capture: got v=%b d=%h want v=1 d=cafef00d", out_valid, out_data);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data, sel_s1, sel_s0, req_ready} !== {1'b0, 32'd0, 2'b00, 4'b0000})
      $display("FAIL mid_async_reset: got v=%b d=%h s=%b%b rdy=%b want all zero", out_valid, out_data, sel_s1, sel_s0, req_ready);
    else pass_cnt++;
    req_valid = 4'b1111;
    req_data0 = 32'h00000055;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) $display("FAIL mid_after_ready: got %b want 0001", req_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 32'h00000055})
      $display("FAIL mid_after_grant: got v=%b src=%0d d=%h want v=1 src=0 d=00000055", out_valid, out_src, out_data);
    else pass_cnt++;
    req_valid = 4'b0;
    @(negedge clk);
  endtask

  task automatic test_drop();
    do_reset();
    req_data0 = 32'h0000600D;
    req_data3 = 32'hBAD00003;
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b0000) $display("FAIL drop_ready_bp: got %b want 0000", req_ready);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 4'b0000;
    out_ready = 1'b1;
    #1;
    total++;
    if ({out_valid, out_src, out_data, req_ready} !== {1'b1, 2'd0, 32'h0000600D, 4'b0000})
      $display("FAIL drop_held: got v=%b src=%0d d=%h rdy=%b want v=1 src=0 d=0000600d rdy=0000", out_valid, out_src, out_data, req_ready);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_src} !== {1'b0, 2'd0}) $display("FAIL drop_idle_%0d: got v=%b src=%0d want v=0 src=0", k, out_valid, out_src);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b0;
    out_ready = 1'b0;
    req_data0 = '0;
    req_data1 = '0;
    req_data2 = '0;
    req_data3 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_drop();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/alu_operand_arbiter.md
Name: alu_operand_arbiter

Overview:
- Shares one 32-bit ALU operand path among four requesters using round-robin arbitration.
- Captures the winning requester's operand into an output register.
- Presents the captured operand downstream with a valid/ready handshake.
- Drives the s1/s0 select pair of the 4:1 operand mux (built from three 2:1 muxes) with the registered grant index, so the mux steers the captured source while the transfer is pending.

Parameters:
WIDTH, 32, operand width in bits. Requester count is fixed at 4.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  4  bit i = requester i has an operand
req_data0  input  WIDTH  requester 0 operand
req_data1  input  WIDTH  requester 1 operand
req_data2  input  WIDTH  requester 2 operand
req_data3  input  WIDTH  requester 3 operand
req_ready  output  4  one-hot accept; combinational
out_valid  output  1  captured operand valid
out_data  output  WIDTH  captured operand
out_src  output  2  index of requester that supplied out_data
out_ready  input  1  downstream accepts
sel_s0  output  1  mux select LSB, equals out_src[0]
sel_s1  output  1  mux select MSB, equals out_src[1]
busy  output  1  equals out_valid

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: out_valid=0, out_data=0, out_src=0, sel_s1/sel_s0=0, busy=0, priority pointer last_grant=3. With last_grant=3, requester 0 has highest priority after reset.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Accept window: open = (state==EMPTY) or (out_valid and out_ready).
- Arbitration (combinational):
  - Scan indices last_grant+1, +2, +3, +4, all mod 4.
  - The first i with req_valid[i]=1 is the winner.
  - req_ready[winner]=1 only while the accept window is open. All other req_ready bits are 0.
  - req_ready never depends on out_ready when in EMPTY.
- On a rising edge with the window open and a winner:
  - out_data <= req_dataW, out_src <= W, last_grant <= W, state <= FULL.
  - Latency from acceptance to out_valid is 1 cycle.
- Window open, no winner:
  - From FULL with a handshake: state <= EMPTY, out_valid <= 0.
  - From EMPTY: state stays EMPTY.
- FULL without a handshake (out_ready=0):
  - out_data, out_src, sel_s* and last_grant are held stable.
  - All req_ready bits are 0.
  - out_valid is never deasserted without a handshake.
- Back-to-back: a handshake and a new acceptance in the same cycle keeps out_valid=1 continuously. Sustained throughput is 1 operand/clock.
- Fairness: a continuously asserting requester waits at most 3 transfers. The pointer wraps from 3 to 0.
- Requester i may drop req_valid[i] before it is granted. The block keeps no per-requester state, and nothing is captured for a dropped request.
- The handshake of requester i completes only in a cycle where req_valid[i] and req_ready[i] are both 1.
- sel_s1/sel_s0 are registered outputs, glitch-free, updated only on acceptance.
- Reset asserted mid-transfer:
  - Immediate (asynchronous) return to reset values.
  - Any pending out_data is discarded.
  - req_ready goes to 0 while rst_n=0.
- No X propagation: out_data is loaded only from the accepted requester.

Test Plan:
1. Reset, then req_valid=4'b0100, req_data2=32'hDEADBEEF, out_ready=1.
   -> req_ready=4'b0100 the same cycle.
   -> Next cycle: out_valid=1, out_data=DEADBEEF, out_src=2, sel_s1=1, sel_s0=0.
   -> Following cycle: out_valid=0.
2. All four req_valid held high, data i = 32'h1000_000i, out_ready=1.
   -> Grants 0,1,2,3,0 on consecutive cycles.
   -> out_valid continuously 1 from the second cycle.
   -> out_data sequence 10000000, 10000001, 10000002, 10000003, 10000000.
3. Requester 1 captured, out_ready=0 for 5 cycles while req_valid=4'b1111.
   -> out_data/out_src/sel held constant, req_ready=0 throughout.
   -> On out_ready=1, requester 2 is granted the same cycle.
4. Wrap-around: last grant to 3, then req_valid=4'b1001.
   -> Requester 0 is granted before 3.
   -> Then requester 3 is granted if it is still requesting.
5. Reset mid-FULL: out_valid=1 with out_data=32'hCAFEF00D, rst_n pulled low between clock edges.
   -> out_valid=0, out_data=0, sel=00 immediately.
   -> After release with req_valid=4'b1111: first grant goes to requester 0.
6. Requester 3 raises then drops req_valid before being granted, while 0 is busy under backpressure.
   -> Requester 3 is never captured.
   -> No spurious out_valid once 0 transfers and req_valid=0.
